// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX arbitration path.
package uart_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, HOLD} arb_state_t;

  // Round-robin successor; wraps correctly for non-power-of-two counts.
  function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned num_req);
    return (ptr + 32'd1 >= num_req) ? 32'd0 : ptr + 32'd1;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus transmitter start/data/busy/done handshake.
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
  import uart_pkg::*;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][BYTE_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           tx_start;
  logic [BYTE_W-1:0]              tx_data;
  logic                           tx_busy;
  logic                           tx_done;

  modport master (
    output req_valid, req_data, req_last, tx_busy, tx_done,
    input  req_ready, tx_start, tx_data
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy, tx_done,
    output req_ready, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of valid at or after ptr, with wrap.
module rr_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);
  int c;

  // Scan from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    c     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (valid[W'(c)]) begin
        found = 1'b1;
        idx   = W'(c);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet lock sharing one UART transmitter among NUM_REQ byte streams.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int STALL_LIMIT = 1023,
  parameter int CNT_W       = 10
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_arbiter_if.slave    bus,
  output logic                grant_active,
  output logic [ID_W-1:0]     grant_id,
  output logic                stall_drop
);
  arb_state_t        state, state_d;
  logic [ID_W-1:0]   rr_ptr, pick_idx, load_idx;
  logic              pick_found, last_q;
  logic              load, grant, release_lock, drop, cnt_clr, cnt_inc;
  logic [CNT_W-1:0]  stall_cnt;
  logic [BYTE_W-1:0] tx_data_q;

  rr_picker #(.N(NUM_REQ), .W(ID_W)) u_pick (
    .valid (bus.req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d      = state;
    load         = 1'b0;
    grant        = 1'b0;
    release_lock = 1'b0;
    drop         = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    case (state)
      IDLE: if (pick_found && !bus.tx_busy) begin
        state_d = ISSUE;
        grant   = 1'b1;
        load    = 1'b1;
      end
      ISSUE: state_d = WAIT_DONE;
      WAIT_DONE: if (bus.tx_done) begin
        if (last_q) begin
          state_d      = IDLE;
          release_lock = 1'b1;
        end else begin
          state_d = HOLD;
          cnt_clr = 1'b1;
        end
      end
      HOLD: if (bus.req_valid[grant_id]) begin
        state_d = ISSUE;
        load    = 1'b1;
      end else if (stall_cnt == CNT_W'(STALL_LIMIT - 1)) begin
        state_d      = IDLE;
        release_lock = 1'b1;
        drop         = 1'b1;
      end else begin
        cnt_inc = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // The byte is captured on entry to ISSUE so tx_data is already valid alongside tx_start.
  assign load_idx = (state == IDLE) ? pick_idx : grant_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      tx_data_q  <= '0;
      last_q     <= 1'b0;
      stall_cnt  <= '0;
      stall_drop <= 1'b0;
    end else begin
      state      <= state_d;
      stall_drop <= drop;
      if (grant) grant_id <= pick_idx;
      if (load) begin
        tx_data_q <= bus.req_data[load_idx];
        last_q    <= bus.req_last[load_idx];
      end
      if (release_lock) rr_ptr <= ID_W'(next_rr(32'(grant_id), NUM_REQ));
      if (cnt_clr)      stall_cnt <= '0;
      else if (cnt_inc) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == ISSUE) bus.req_ready[grant_id] = 1'b1;
  end

  assign bus.tx_start = (state == ISSUE);
  assign bus.tx_data  = tx_data_q;
  assign grant_active = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: stimulus queues expected grants, a negedge monitor checks each tx_start/tx_done/stall_drop.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NR = 4, IW = 2, SL = 8, CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          grant_active, stall_drop;
  logic [IW-1:0] grant_id;
  logic          mdl_busy = 1'b0, mdl_done = 1'b0, tb_busy = 1'b0, tb_done = 1'b0;
  logic [NR-1:0] rdy;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus();
  assign bus.tx_busy = mdl_busy | tb_busy;
  assign bus.tx_done = mdl_done | tb_done;

  uart_tx_arbiter #(.NUM_REQ(NR), .ID_W(IW), .STALL_LIMIT(SL), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .grant_active (grant_active),
    .grant_id     (grant_id),
    .stall_drop   (stall_drop)
  );

  typedef struct {int id; logic [7:0] d; logic l; int rf;} exp_t;  // rf: 0 none, 1 gap from tx_done, 2 gap from busy mark
  typedef struct {logic [7:0] d; logic l;} rb_t;

  exp_t sb[$];
  rb_t  rq[NR][$];
  int   tot = 0, bad = 0, cyc = 0, n_start = 0, n_drop = 0, done_cyc = -100, mark = 0, dly = 3;
  bit   tx_auto = 1'b1, drop_ok = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tot++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", nm, got, exp, cyc);
    end
  endtask

  task automatic push(input int id, input logic [7:0] d, input logic l, input int rf);
    rb_t  b;
    exp_t e;
    b.d = d; b.l = l;
    e.id = id; e.d = d; e.l = l; e.rf = rf;
    rq[id].push_back(b);
    sb.push_back(e);
  endtask

  function automatic bit quiet();
    bit q;
    q = (sb.size() == 0) && !grant_active && !bus.tx_busy && !bus.tx_done;
    for (int i = 0; i < NR; i++) if (rq[i].size() != 0) q = 1'b0;
    return q;
  endfunction

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (quiet()) begin ok = 1'b1; break; end
    end
    chk({nm, "_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_sb(input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (sb.size() == 0) begin ok = 1'b1; break; end
    end
    chk({nm, "_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic do_reset(input bit check);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (check) begin
      chk("rst_tx_start", 32'(bus.tx_start), 0);
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      chk("rst_tx_data", 32'(bus.tx_data), 0);
      chk("rst_grant_active", 32'(grant_active), 0);
      chk("rst_grant_id", 32'(grant_id), 0);
      chk("rst_stall_drop", 32'(stall_drop), 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requester side: pop the head byte once its ready strobe has been seen.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      rdy = bus.req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (rdy[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          bus.req_valid[i] = 1'b1;
          bus.req_data[i]  = rq[i][0].d;
          bus.req_last[i]  = rq[i][0].l;
        end else begin
          bus.req_valid[i] = 1'b0;
          bus.req_data[i]  = '0;
          bus.req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Transmitter model: busy after tx_start, tx_done pulse dly cycles after it.
  initial forever begin
    @(negedge clk);
    if (bus.tx_start && tx_auto && !rst) begin
      @(posedge clk); #1 mdl_busy = 1'b1;
      repeat (dly - 1) @(posedge clk);
      #1 mdl_done = 1'b1;
      @(posedge clk); #1 mdl_done = 1'b0; mdl_busy = 1'b0;
    end
  end

  initial begin
    exp_t       e;
    bit         inflight, post, post_exp, cur_last;
    logic [7:0] cur_d;
    inflight = 1'b0; post = 1'b0; post_exp = 1'b0; cur_last = 1'b1; cur_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        inflight = 1'b0;
        post     = 1'b0;
      end else begin
        if (post) begin
          chk("post_done_grant_active", 32'(grant_active), 32'(post_exp));
          post = 1'b0;
        end
        if (bus.tx_start) begin
          n_start++;
          if (sb.size() == 0) begin
            tot++; bad++;
            $display("FAIL unexpected_tx_start id=%0d data=%0h @cyc %0d", grant_id, bus.tx_data, cyc);
            cur_last = 1'b1;
          end else begin
            e = sb.pop_front();
            chk("start_grant_id", 32'(grant_id), 32'(e.id));
            chk("start_tx_data", 32'(bus.tx_data), 32'(e.d));
            chk("start_req_ready", 32'(bus.req_ready), 32'(1 << e.id));
            chk("start_grant_active", 32'(grant_active), 1);
            if (e.rf == 1) chk("gap_after_done", 32'(cyc), 32'(done_cyc + 2));
            if (e.rf == 2) chk("gap_after_busy", 32'(cyc), 32'(mark + 2));
            cur_last = e.l;
          end
          inflight = 1'b1;
          cur_d    = bus.tx_data;
        end else if (bus.req_ready != '0) begin
          chk("stray_req_ready", 32'(bus.req_ready), 0);
        end
        if (bus.tx_done) begin
          if (inflight) chk("tx_data_held", 32'(bus.tx_data), 32'(cur_d));
          post     = 1'b1;
          post_exp = inflight ? !cur_last : 1'b0;
          inflight = 1'b0;
          done_cyc = cyc;
        end
        if (stall_drop) begin
          n_drop++;
          chk("drop_expected", 32'(drop_ok), 1);
          chk("drop_cycle", 32'(cyc), 32'(done_cyc + 1 + SL));
          chk("drop_grant_active", 32'(grant_active), 0);
        end
      end
    end
  end

  initial begin
    int n0;
    do_reset(1'b1);

    // single byte from req 2 with a slow transmitter, then prove rr_ptr landed on 3
    dly = 100;
    n0  = n_start;
    push(2, 8'hA5, 1'b1, 0);
    wait_idle("single");
    chk("single_start_count", 32'(n_start - n0), 1);
    dly = 3;
    push(3, 8'h33, 1'b1, 0);
    push(1, 8'h31, 1'b1, 0);
    wait_idle("rr_after_single");

    // fairness: all four valid from reset, req 0 has a second packet queued
    do_reset(1'b0);
    push(0, 8'hC0, 1'b1, 0);
    push(1, 8'hC1, 1'b1, 0);
    push(2, 8'hC2, 1'b1, 0);
    push(3, 8'hC3, 1'b1, 0);
    push(0, 8'hC4, 1'b1, 0);
    wait_idle("fairness");

    // packet lock: move rr_ptr to 1, then req 1 three-byte packet against a waiting req 0
    do_reset(1'b0);
    push(0, 8'h20, 1'b1, 0);
    wait_idle("lock_pre");
    push(1, 8'h10, 1'b0, 0);
    push(1, 8'h11, 1'b0, 1);
    push(1, 8'h12, 1'b1, 1);
    push(0, 8'h21, 1'b1, 0);
    wait_idle("lock");

    // stall timeout: req 3 leaves its packet open; req 0 appears while the lock is held
    do_reset(1'b0);
    drop_ok = 1'b1;
    n0 = n_drop;
    push(3, 8'h55, 1'b0, 0);
    wait_sb("stall_start");
    repeat (5) @(negedge clk);
    push(0, 8'h60, 1'b1, 0);
    wait_idle("stall");
    chk("stall_drop_count", 32'(n_drop - n0), 1);
    drop_ok = 1'b0;

    // busy blocking
    do_reset(1'b0);
    tb_busy = 1'b1;
    n0 = n_start;
    push(0, 8'h70, 1'b1, 2);
    repeat (20) @(negedge clk);
    chk("busy_no_start", 32'(n_start - n0), 0);
    chk("busy_no_grant", 32'(grant_active), 0);
    @(posedge clk); #1 tb_busy = 1'b0;
    mark = cyc - 1;
    wait_idle("busy");

    // reset mid-packet, stray tx_done, then arbitration restarts from rr_ptr=0
    do_reset(1'b0);
    push(2, 8'h77, 1'b1, 0);
    wait_idle("rstmid_pre");
    tx_auto = 1'b0;
    push(2, 8'h78, 1'b1, 0);
    wait_sb("rstmid_start");
    repeat (3) @(negedge clk);
    chk("rstmid_in_wait", 32'(grant_active), 1);
    do_reset(1'b1);
    @(posedge clk); #1 tb_done = 1'b1;
    @(posedge clk); #1 tb_done = 1'b0;
    repeat (5) @(negedge clk);
    chk("rstmid_stray_done_idle", 32'(grant_active), 0);
    tx_auto = 1'b1;
    push(1, 8'h81, 1'b1, 0);
    push(3, 8'h83, 1'b1, 0);
    wait_idle("rstmid_post");

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
